// File: rtl/pdp8_ptr.sv
// PDP-8 paper-tape reader IOT device: RSF/RRB/RFC/RPE decode, one-character
// fetch handshake against a tape source, done flag and interrupt enable.
module pdp8_ptr #(
  parameter logic [5:0] DEV_CODE  = 6'o01,
  parameter logic [3:0] IOT_STATE = 4'h1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iot,
  input  logic [3:0]  state,
  input  logic [11:0] mb,
  input  logic [11:0] io_data_in,
  input  logic [5:0]  io_select,
  output logic        io_selected,
  output logic [11:0] io_data_out,
  output logic        io_data_avail,
  output logic        io_interrupt,
  output logic        io_skip,
  output logic        io_clear_ac,
  input  logic [7:0]  tape_data,
  input  logic        tape_valid,
  output logic        tape_ready
);

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  fetch_state_t fsm_q, fsm_d;
  logic         flag_q, flag_d;
  logic         ie_q, ie_d;
  logic [7:0]   rbuf_q, rbuf_d;

  logic sel;
  logic strobe;
  logic xfer;
  logic unused_inputs;

  // AC input and the upper MB bits play no part in this device's decode.
  assign unused_inputs = ^{io_data_in, mb[11:3]};

  assign io_selected   = (io_select == DEV_CODE);
  assign sel           = iot & io_selected;
  assign strobe        = sel & (state == IOT_STATE);

  assign io_skip       = sel & mb[0] & flag_q;
  assign io_data_avail = sel & mb[1];
  assign io_data_out   = io_data_avail ? {4'b0000, rbuf_q} : 12'o0000;
  assign io_interrupt  = flag_q & ie_q;
  assign io_clear_ac   = 1'b0;

  assign tape_ready    = (fsm_q == FETCH);
  assign xfer          = tape_valid & tape_ready;

  always_comb begin
    fsm_d  = fsm_q;
    flag_d = flag_q;
    ie_d   = ie_q;
    rbuf_d = rbuf_q;

    case (fsm_q)
      IDLE:    if (strobe && mb[2]) fsm_d = FETCH;
      FETCH:   if (tape_valid) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase

    if (strobe && mb[2:0] == 3'b000) ie_d = 1'b1;

    // Clear first so a completing transfer in the same cycle leaves flag set.
    if (strobe && (mb[1] || mb[2])) flag_d = 1'b0;
    if (xfer) begin
      flag_d = 1'b1;
      rbuf_d = tape_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm_q  <= IDLE;
      flag_q <= 1'b0;
      ie_q   <= 1'b1;
      rbuf_q <= 8'h00;
    end else begin
      fsm_q  <= fsm_d;
      flag_q <= flag_d;
      ie_q   <= ie_d;
      rbuf_q <= rbuf_d;
    end
  end

endmodule

// File: tb/tb_pdp8_ptr.sv
// Self-checking bench for pdp8_ptr: expected characters go into a scoreboard
// queue when the tape supplies them and are popped when RRB reads them back.
module tb_pdp8_ptr;

  localparam logic [5:0] DEV  = 6'o01;
  localparam logic [3:0] IOTS = 4'h1;

  logic        clk = 1'b0;
  logic        reset;
  logic        iot;
  logic [3:0]  state;
  logic [11:0] mb;
  logic [11:0] io_data_in;
  logic [5:0]  io_select;
  logic        io_selected;
  logic [11:0] io_data_out;
  logic        io_data_avail;
  logic        io_interrupt;
  logic        io_skip;
  logic        io_clear_ac;
  logic [7:0]  tape_data;
  logic        tape_valid;
  logic        tape_ready;

  int checks = 0;
  int fails  = 0;
  logic [7:0] sb[$];
  logic [7:0] model_rbuf;

  pdp8_ptr #(.DEV_CODE(DEV), .IOT_STATE(IOTS)) dut (
    .clk          (clk),
    .reset        (reset),
    .iot          (iot),
    .state        (state),
    .mb           (mb),
    .io_data_in   (io_data_in),
    .io_select    (io_select),
    .io_selected  (io_selected),
    .io_data_out  (io_data_out),
    .io_data_avail(io_data_avail),
    .io_interrupt (io_interrupt),
    .io_skip      (io_skip),
    .io_clear_ac  (io_clear_ac),
    .tape_data    (tape_data),
    .tape_valid   (tape_valid),
    .tape_ready   (tape_ready)
  );

  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    iot       = 1'b0;
    state     = 4'h0;
    mb        = 12'o0000;
    io_select = DEV;
  endtask

  task automatic do_iot(input logic [11:0] m, input logic [3:0] st);
    iot       = 1'b1;
    state     = st;
    mb        = m;
    io_select = DEV;
  endtask

  // Waits (bounded) for tape_ready, then presents one character for one edge.
  task automatic feed_byte(input logic [7:0] d, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (tape_ready) begin
        tape_data  = d;
        tape_valid = 1'b1;
        ok = 1'b1;
        @(posedge clk);
        #1;
        tape_valid = 1'b0;
        sb.push_back(d);
        model_rbuf = d;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_bus();
    io_data_in = 12'o7777;
    tape_data  = 8'h00;
    tape_valid = 1'b0;
    model_rbuf = 8'h00;
    repeat (3) cycle();
    do_iot(12'o6012, IOTS);
    @(negedge clk);
    checks++; if (tape_ready !== 1'b0) begin fails++; $display("FAIL reset_tape_ready got %b want 0", tape_ready); end
    checks++; if (io_interrupt !== 1'b0) begin fails++; $display("FAIL reset_interrupt got %b want 0", io_interrupt); end
    checks++; if (io_data_out !== 12'o0000 || io_data_avail !== 1'b1) begin fails++; $display("FAIL reset_rrb got %o/%b want 0000/1", io_data_out, io_data_avail); end
    checks++; if (io_clear_ac !== 1'b0 || io_selected !== 1'b1) begin fails++; $display("FAIL reset_misc got clr=%b sel=%b want 0/1", io_clear_ac, io_selected); end
    cycle();
    idle_bus();
    reset = 1'b1;
    cycle();
    $display("reset done");
  endtask

  task automatic test_fetch();
    int ready_cnt = 0;
    do_iot(12'o6014, IOTS);
    cycle();
    idle_bus();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (tape_ready) ready_cnt++;
      if (k == 2) begin
        tape_data  = 8'hA5;
        tape_valid = 1'b1;
      end
      cycle();
    end
    tape_valid = 1'b0;
    sb.push_back(8'hA5);
    model_rbuf = 8'hA5;
    @(negedge clk);
    checks++; if (ready_cnt != 3) begin fails++; $display("FAIL fetch_ready_cycles got %0d want 3", ready_cnt); end
    checks++; if (tape_ready !== 1'b0) begin fails++; $display("FAIL fetch_ready_drop got %b want 0", tape_ready); end
    checks++; if (io_interrupt !== 1'b1) begin fails++; $display("FAIL fetch_interrupt got %b want 1", io_interrupt); end
    cycle();
    do_iot(12'o6011, IOTS);
    @(negedge clk);
    checks++; if (io_skip !== 1'b1 || io_data_avail !== 1'b0) begin fails++; $display("FAIL rsf_skip got skip=%b avail=%b want 1/0", io_skip, io_data_avail); end
    cycle();
    idle_bus();
    $display("fetch: char A5 accepted after %0d ready cycles", ready_cnt);
  endtask

  task automatic test_rrb();
    logic [7:0] exp;
    do_iot(12'o6012, IOTS);
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (io_data_out !== {4'b0000, exp} || io_data_avail !== 1'b1) begin fails++; $display("FAIL rrb_data got %o/%b want %o/1", io_data_out, io_data_avail, {4'b0000, exp}); end
    checks++; if (io_clear_ac !== 1'b0) begin fails++; $display("FAIL rrb_clear_ac got %b want 0", io_clear_ac); end
    cycle();
    do_iot(12'o6011, IOTS);
    @(negedge clk);
    checks++; if (io_skip !== 1'b0 || io_interrupt !== 1'b0) begin fails++; $display("FAIL rrb_flag_clear got skip=%b irq=%b want 0/0", io_skip, io_interrupt); end
    cycle();
    do_iot(12'o6012, IOTS);
    @(negedge clk);
    checks++; if (io_data_out !== {4'b0000, model_rbuf}) begin fails++; $display("FAIL rrb_repeat got %o want %o", io_data_out, {4'b0000, model_rbuf}); end
    cycle();
    idle_bus();
    $display("rrb: read %o", {4'b0000, exp});
  endtask

  task automatic test_rfc_during_fetch();
    logic [7:0] exp;
    do_iot(12'o6014, IOTS);
    cycle();
    do_iot(12'o6014, IOTS);
    cycle();
    idle_bus();
    @(negedge clk);
    checks++; if (tape_ready !== 1'b1) begin fails++; $display("FAIL rfc_in_fetch_ready got %b want 1", tape_ready); end
    tape_data  = 8'h5A;
    tape_valid = 1'b1;
    cycle();
    sb.push_back(8'h5A);
    model_rbuf = 8'h5A;
    tape_data  = 8'hFF;
    @(negedge clk);
    checks++; if (tape_ready !== 1'b0) begin fails++; $display("FAIL single_xfer_ready got %b want 0", tape_ready); end
    cycle();
    cycle();
    tape_valid = 1'b0;
    do_iot(12'o6012, IOTS);
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (io_data_out !== {4'b0000, exp}) begin fails++; $display("FAIL single_xfer_data got %o want %o", io_data_out, {4'b0000, exp}); end
    cycle();
    idle_bus();
    $display("rfc during fetch: single char %h", exp);
  endtask

  task automatic test_set_wins();
    logic [7:0] exp;
    do_iot(12'o6014, IOTS);
    cycle();
    idle_bus();
    cycle();
    do_iot(12'o6012, IOTS);
    tape_data  = 8'h3C;
    tape_valid = 1'b1;
    @(negedge clk);
    checks++; if (io_data_out !== {4'b0000, model_rbuf}) begin fails++; $display("FAIL coincident_old_data got %o want %o", io_data_out, {4'b0000, model_rbuf}); end
    cycle();
    tape_valid = 1'b0;
    sb.push_back(8'h3C);
    model_rbuf = 8'h3C;
    idle_bus();
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b1) begin fails++; $display("FAIL set_wins_flag got %b want 1", io_interrupt); end
    cycle();
    do_iot(12'o0012, 4'h2);
    @(negedge clk);
    exp = sb.pop_front();
    checks++; if (io_data_out !== {4'b0000, exp} || io_data_avail !== 1'b1) begin fails++; $display("FAIL nonstrobe_rrb got %o/%b want %o/1", io_data_out, io_data_avail, {4'b0000, exp}); end
    cycle();
    idle_bus();
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b1) begin fails++; $display("FAIL nonstrobe_no_clear got %b want 1", io_interrupt); end
    cycle();
    $display("set wins: rbuf %h flag kept", exp);
  endtask

  task automatic test_unselected();
    iot       = 1'b1;
    io_select = 6'o02;
    mb        = 12'o0017;
    state     = IOTS;
    @(negedge clk);
    checks++; if (io_selected !== 1'b0) begin fails++; $display("FAIL unsel_selected got %b want 0", io_selected); end
    checks++; if ({io_skip, io_data_avail, io_clear_ac, io_data_out} !== 15'd0) begin fails++; $display("FAIL unsel_outputs got skip=%b avail=%b clr=%b data=%o want all 0", io_skip, io_data_avail, io_clear_ac, io_data_out); end
    cycle();
    cycle();
    idle_bus();
    @(negedge clk);
    checks++; if (io_interrupt !== 1'b1 || tape_ready !== 1'b0) begin fails++; $display("FAIL unsel_no_change got irq=%b ready=%b want 1/0", io_interrupt, tape_ready); end
    cycle();
    $display("unselected: no effect");
  endtask

  task automatic test_reset_mid_fetch();
    do_iot(12'o6014, IOTS);
    cycle();
    idle_bus();
    @(negedge clk);
    checks++; if (tape_ready !== 1'b1) begin fails++; $display("FAIL midfetch_enter got %b want 1", tape_ready); end
    reset      = 1'b0;
    tape_data  = 8'h77;
    tape_valid = 1'b1;
    cycle();
    reset = 1'b1;
    model_rbuf = 8'h00;
    @(negedge clk);
    checks++; if (tape_ready !== 1'b0 || io_interrupt !== 1'b0) begin fails++; $display("FAIL midfetch_reset got ready=%b irq=%b want 0/0", tape_ready, io_interrupt); end
    cycle();
    @(negedge clk);
    checks++; if (tape_ready !== 1'b0 || io_interrupt !== 1'b0) begin fails++; $display("FAIL idle_ignores_valid got ready=%b irq=%b want 0/0", tape_ready, io_interrupt); end
    tape_valid = 1'b0;
    cycle();
    do_iot(12'o6012, IOTS);
    @(negedge clk);
    checks++; if (io_data_out !== {4'b0000, model_rbuf}) begin fails++; $display("FAIL midfetch_rbuf got %o want %o", io_data_out, {4'b0000, model_rbuf}); end
    cycle();
    idle_bus();
    $display("reset mid-fetch: aborted");
  endtask

  task automatic test_back_to_back();
    bit ok;
    logic [7:0] d;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      do_iot(12'o6014, IOTS);
      cycle();
      idle_bus();
      feed_byte(d, ok);
      checks++; if (!ok) begin fails++; $display("FAIL b2b_timeout char %0d got no tape_ready want ready", i); end
      @(negedge clk);
      checks++; if (io_interrupt !== ok) begin fails++; $display("FAIL b2b_interrupt got %b want %b", io_interrupt, ok); end
      cycle();
      do_iot(12'o6012, IOTS);
      @(negedge clk);
      if (ok) begin
        exp = sb.pop_front();
        checks++; if (io_data_out !== {4'b0000, exp}) begin fails++; $display("FAIL b2b_data got %o want %o", io_data_out, {4'b0000, exp}); end
      end
      cycle();
      idle_bus();
      $display("b2b %0d: char %h read %o", i, d, io_data_out);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_rrb();
    test_rfc_during_fetch();
    test_set_wins();
    test_unselected();
    test_reset_mid_fetch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
